// File: rtl/regfile_wb_arbiter.sv
// Write-port owner for the 32-entry register file: clears x1..x(N-1) after reset,
// then round-robin arbitrates two valid/ready writeback requesters onto registered write outputs.
module regfile_wb_arbiter #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 5,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall,
    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_data,
    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_data,
    output logic                  rf_we,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic                  init_done
);

    // state   | meaning
    // S_CLEAR | writing zero to x1..x(2**ADDR_WIDTH-1), one index per cycle; no grants
    // S_RUN   | arbitrating requesters A and B onto the write port
    typedef enum logic {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] IDX_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_t                state, state_next;
    logic [ADDR_WIDTH-1:0] clr_idx, clr_idx_next;
    logic                  last_b, last_b_next;
    logic                  grant_a, grant_b;
    logic                  we_next;
    logic [ADDR_WIDTH-1:0] waddr_next;
    logic [DATA_WIDTH-1:0] wdata_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= CLEAR_ON_RESET ? S_CLEAR : S_RUN;
            clr_idx  <= IDX_ONE;
            last_b   <= 1'b1;
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            state    <= state_next;
            clr_idx  <= clr_idx_next;
            last_b   <= last_b_next;
            rf_we    <= we_next;
            rf_waddr <= waddr_next;
            rf_wdata <= wdata_next;
        end
    end

    always_comb begin
        state_next   = state;
        clr_idx_next = clr_idx;
        last_b_next  = last_b;
        grant_a      = 1'b0;
        grant_b      = 1'b0;
        we_next      = 1'b0;
        waddr_next   = rf_waddr;
        wdata_next   = rf_wdata;
        case (state)
            S_CLEAR: begin
                // clr_idx wraps to 0 once the top index has been issued
                if (clr_idx == '0) begin
                    state_next = S_RUN;
                end else begin
                    we_next      = 1'b1;
                    waddr_next   = clr_idx;
                    wdata_next   = '0;
                    clr_idx_next = clr_idx + IDX_ONE;
                end
            end
            S_RUN: begin
                if (!stall) begin
                    grant_a = a_valid && (!b_valid || last_b);
                    grant_b = b_valid && !grant_a;
                end
                if (grant_a) begin
                    we_next     = (a_addr != '0);
                    waddr_next  = a_addr;
                    wdata_next  = a_data;
                    last_b_next = 1'b0;
                end else if (grant_b) begin
                    we_next     = (b_addr != '0);
                    waddr_next  = b_addr;
                    wdata_next  = b_data;
                    last_b_next = 1'b1;
                end
            end
            default: state_next = S_RUN;
        endcase
    end

    assign a_ready   = grant_a;
    assign b_ready   = grant_b;
    assign init_done = (state == S_RUN);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: clear sequence, directed vector table, random traffic
// against a queue-free arbitration model, and reset during CLEAR.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        a_valid = 1'b0, b_valid = 1'b0;
    logic        a_ready, b_ready;
    logic [4:0]  a_addr = '0, b_addr = '0;
    logic [31:0] a_data = '0, b_data = '0;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        init_done;

    int vectors = 0;
    int miscompares = 0;
    bit model_last_b;

    regfile_wb_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .CLEAR_ON_RESET(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .init_done(init_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        bit        st;
        bit        av;
        bit [4:0]  aa;
        bit [31:0] ad;
        bit        bv;
        bit [4:0]  ba;
        bit [31:0] bd;
        bit        exp_ar;
        bit        exp_br;
        bit        exp_we;
        bit [4:0]  exp_addr;
        bit [31:0] exp_data;
    } vec_t;

    vec_t tbl[12];

    task automatic drive(input bit st, input bit av, input bit [4:0] aa, input bit [31:0] ad,
                         input bit bv, input bit [4:0] ba, input bit [31:0] bd);
        stall = st; a_valid = av; a_addr = aa; a_data = ad;
        b_valid = bv; b_addr = ba; b_data = bd;
    endtask

    initial begin
        bit        hold_a, hold_b;
        bit        st, av, bv, ga, gb, ewe;
        bit [4:0]  aa, ba, eaddr;
        bit [31:0] ad, bd, edata;

        // stall | A valid/addr/data | B valid/addr/data | ready A/B | next-cycle write
        tbl[0]  = '{0, 1, 5'd3, 32'h1,        1, 5'd4, 32'h2,        1, 0, 1, 5'd3, 32'h1};
        tbl[1]  = '{0, 1, 5'd3, 32'h1,        1, 5'd4, 32'h2,        0, 1, 1, 5'd4, 32'h2};
        tbl[2]  = '{0, 1, 5'd3, 32'h1,        1, 5'd4, 32'h2,        1, 0, 1, 5'd3, 32'h1};
        tbl[3]  = '{0, 1, 5'd3, 32'h1,        1, 5'd4, 32'h2,        0, 1, 1, 5'd4, 32'h2};
        tbl[4]  = '{0, 1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0,        1, 0, 1, 5'd5, 32'hDEADBEEF};
        tbl[5]  = '{0, 0, 5'd0, 32'h0,        1, 5'd0, 32'hFFFFFFFF, 0, 1, 0, 5'd0, 32'h0};
        tbl[6]  = '{1, 1, 5'd7, 32'h77,       0, 5'd0, 32'h0,        0, 0, 0, 5'd0, 32'h0};
        tbl[7]  = '{1, 1, 5'd7, 32'h77,       0, 5'd0, 32'h0,        0, 0, 0, 5'd0, 32'h0};
        tbl[8]  = '{1, 1, 5'd7, 32'h77,       0, 5'd0, 32'h0,        0, 0, 0, 5'd0, 32'h0};
        tbl[9]  = '{0, 1, 5'd7, 32'h77,       0, 5'd0, 32'h0,        1, 0, 1, 5'd7, 32'h77};
        tbl[10] = '{0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        0, 0, 0, 5'd0, 32'h0};
        tbl[11] = '{0, 1, 5'd8, 32'h88,       1, 5'd9, 32'h99,       0, 1, 1, 5'd9, 32'h99};

        // reset values, with A requesting to show nothing is granted
        a_valid = 1'b1; a_addr = 5'd2; a_data = 32'h5;
        repeat (2) @(negedge clk);
        chk("reset rf_we", rf_we, 0);
        chk("reset rf_waddr", rf_waddr, 0);
        chk("reset rf_wdata", rf_wdata, 0);
        chk("reset init_done", init_done, 0);
        chk("reset a_ready", a_ready, 0);

        // CLEAR sequence: addrs 1..31 with zero data, A held valid but never granted
        rst_n = 1'b1;
        for (int k = 1; k <= 31; k++) begin
            @(negedge clk);
            chk("clear rf_we", rf_we, 1);
            chk("clear rf_waddr", rf_waddr, k);
            chk("clear rf_wdata", rf_wdata, 0);
            chk("clear a_ready", a_ready, 0);
            chk("clear init_done", init_done, 0);
        end
        @(negedge clk);
        chk("run init_done", init_done, 1);
        chk("run first rf_we", rf_we, 0);
        chk("run first a_ready", a_ready, 1);
        a_valid = 1'b0;
        model_last_b = 1'b1;

        // directed table
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].st, tbl[i].av, tbl[i].aa, tbl[i].ad, tbl[i].bv, tbl[i].ba, tbl[i].bd);
            #1;
            chk($sformatf("tbl%0d a_ready", i), a_ready, tbl[i].exp_ar);
            chk($sformatf("tbl%0d b_ready", i), b_ready, tbl[i].exp_br);
            if (tbl[i].exp_ar) model_last_b = 1'b0;
            if (tbl[i].exp_br) model_last_b = 1'b1;
            @(negedge clk);
            chk($sformatf("tbl%0d rf_we", i), rf_we, tbl[i].exp_we);
            if (tbl[i].exp_we) begin
                chk($sformatf("tbl%0d rf_waddr", i), rf_waddr, tbl[i].exp_addr);
                chk($sformatf("tbl%0d rf_wdata", i), rf_wdata, tbl[i].exp_data);
            end
        end

        // random traffic; requesters hold addr/data while waiting
        hold_a = 0; hold_b = 0;
        av = 0; aa = 0; ad = 0; bv = 0; ba = 0; bd = 0;
        for (int n = 0; n < 400; n++) begin
            st = ($urandom_range(0, 3) == 0);
            if (!hold_a) begin
                av = $urandom_range(0, 1); aa = 5'($urandom_range(0, 31)); ad = $urandom;
            end
            if (!hold_b) begin
                bv = $urandom_range(0, 1); ba = 5'($urandom_range(0, 31)); bd = $urandom;
            end
            drive(st, av, aa, ad, bv, ba, bd);
            ga = 0; gb = 0;
            if (!st) begin
                if (av && bv) begin
                    if (model_last_b) ga = 1; else gb = 1;
                end else begin
                    ga = av;
                    gb = bv;
                end
            end
            ewe = 0; eaddr = 0; edata = 0;
            if (ga) begin ewe = (aa != 0); eaddr = aa; edata = ad; model_last_b = 0; end
            if (gb) begin ewe = (ba != 0); eaddr = ba; edata = bd; model_last_b = 1; end
            #1;
            chk("rand a_ready", a_ready, ga);
            chk("rand b_ready", b_ready, gb);
            @(negedge clk);
            chk("rand rf_we", rf_we, ewe);
            if (ewe) begin
                chk("rand rf_waddr", rf_waddr, eaddr);
                chk("rand rf_wdata", rf_wdata, edata);
            end
            hold_a = av && !ga;
            hold_b = bv && !gb;
        end
        drive(0, 0, 0, 0, 0, 0, 0);

        // reset asserted mid-CLEAR when clr_idx = 10
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (9) @(negedge clk);
        chk("mid-clear rf_waddr", rf_waddr, 9);
        rst_n = 1'b0;
        #1;
        chk("async rst rf_we", rf_we, 0);
        chk("async rst rf_waddr", rf_waddr, 0);
        chk("async rst init_done", init_done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("restart rf_we", rf_we, 1);
        chk("restart rf_waddr", rf_waddr, 1);
        @(negedge clk);
        chk("restart rf_waddr+1", rf_waddr, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
